// File: rtl/wave_pkg.sv
// wave_pkg: shared constants, enums and the rate-to-step helper for the wave fetch scheduler
package wave_pkg;
    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 10;
    localparam int PHASE_W = 16;
    localparam int WAVE_W  = 2;

    typedef enum logic [WAVE_W-1:0] {SINE, SQUARE, TRIANGLE, SAWTOOTH} wave_e;

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, PRESENT} sched_state_e;

    // Rate r advances the sample index by 2^r, i.e. the phase by 2^(PHASE_W-ADDR_W+r).
    function automatic logic [PHASE_W-1:0] step_for_rate(input logic [1:0] rate);
        logic [PHASE_W-1:0] one;
        one = 1;
        return one << (PHASE_W - ADDR_W + 32'(rate));
    endfunction
endpackage

// File: rtl/wave_phase_acc.sv
// wave_phase_acc: phase accumulator with wrap detect and period-aligned wave/rate latching
//   clk, rst   : clock, async active-high reset
//   advance_i  : step the phase by the latched rate
//   restart_i  : clear phase and latch wave/rate from sel_i (wins over advance_i)
//   sel_i      : [3:2] waveform, [1:0] rate
//   index_o    : current sample index (top ADDR_W phase bits)
//   wave_o     : latched waveform
//   wrap_o     : the next advance carries out of the phase register
module wave_phase_acc
    import wave_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              advance_i,
    input  logic              restart_i,
    input  logic [3:0]        sel_i,
    output logic [ADDR_W-1:0] index_o,
    output logic [WAVE_W-1:0] wave_o,
    output logic              wrap_o
);
    logic [PHASE_W-1:0] phase_q, phase_d, sum;
    logic [1:0]         rate_q, rate_d;
    wave_e              wave_q, wave_d;
    logic               relatch;

    always_comb {wrap_o, sum} = {1'b0, phase_q} + {1'b0, step_for_rate(rate_q)};

    // Wave and rate only change on a restart or at the wrap, so a period is never mixed.
    always_comb begin
        relatch = restart_i | (advance_i & wrap_o);
        phase_d = restart_i ? '0 : advance_i ? sum : phase_q;
        wave_d  = relatch ? wave_e'(sel_i[3:2]) : wave_q;
        rate_d  = relatch ? sel_i[1:0] : rate_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            wave_q  <= SINE;
            rate_q  <= '0;
        end else begin
            phase_q <= phase_d;
            wave_q  <= wave_d;
            rate_q  <= rate_d;
        end
    end

    assign index_o = phase_q[PHASE_W-1 -: ADDR_W];
    assign wave_o  = wave_q;
endmodule

// File: rtl/wave_fetch_scheduler.sv
// wave_fetch_scheduler: fetches waveform samples from memory and hands them to the SPI transmitter
//   clk, rst         : clock, async active-high reset
//   enable_i         : level-sensitive run request
//   selector_i       : [3:2] waveform, [1:0] rate
//   mem_addr_o       : {wave, index} read address
//   mem_rd_o         : read strobe, data returns on mem_data_i one cycle later
//   mem_data_i       : registered memory read data
//   sample_data_o    : sample to transmitter
//   sample_valid_o   : sample_data_o valid
//   sample_ready_i   : transmitter accepts sample
//   period_done_o    : pulse the cycle after an accept that wrapped the phase
//   busy_o           : FSM not idle
module wave_fetch_scheduler
    import wave_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable_i,
    input  logic [3:0]               selector_i,
    output logic [WAVE_W+ADDR_W-1:0] mem_addr_o,
    output logic                     mem_rd_o,
    input  logic [DATA_W-1:0]        mem_data_i,
    output logic [DATA_W-1:0]        sample_data_o,
    output logic                     sample_valid_o,
    input  logic                     sample_ready_i,
    output logic                     period_done_o,
    output logic                     busy_o
);
    sched_state_e      state_q, state_d;
    logic [DATA_W-1:0] sample_data_q, sample_data_d;
    logic              sample_valid_q, sample_valid_d;
    logic              period_done_q, period_done_d;
    logic [ADDR_W-1:0] index;
    logic [WAVE_W-1:0] wave;
    logic              wrap, accept, advance, restart;

    assign accept  = (state_q == PRESENT) & sample_valid_q & sample_ready_i;
    // Leaving IDLE and dropping back to IDLE both start from phase 0.
    assign restart = ((state_q == IDLE) & enable_i) | (accept & ~enable_i);
    assign advance = accept & enable_i;

    wave_phase_acc u_acc (
        .clk       (clk),
        .rst       (rst),
        .advance_i (advance),
        .restart_i (restart),
        .sel_i     (selector_i),
        .index_o   (index),
        .wave_o    (wave),
        .wrap_o    (wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = enable_i ? FETCH : IDLE;
            FETCH:   state_d = CAPTURE;
            CAPTURE: state_d = PRESENT;
            PRESENT: state_d = !accept ? PRESENT : enable_i ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_o = (state_q == FETCH);
        busy_o   = (state_q != IDLE);
    end

    always_comb begin
        sample_data_d  = (state_q == CAPTURE) ? mem_data_i : sample_data_q;
        sample_valid_d = (state_q == CAPTURE) ? 1'b1 : accept ? 1'b0 : sample_valid_q;
        period_done_d  = accept & wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            period_done_q  <= 1'b0;
        end else begin
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
            period_done_q  <= period_done_d;
        end
    end

    assign mem_addr_o     = {wave, index};
    assign sample_data_o  = sample_data_q;
    assign sample_valid_o = sample_valid_q;
    assign period_done_o  = period_done_q;
endmodule

// File: tb/tb_wave_fetch_scheduler.sv
// tb_wave_fetch_scheduler: self-checking bench for wave_fetch_scheduler
module tb_wave_fetch_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_i = 1'b0;
    logic [3:0]  selector_i = '0;
    logic [10:0] mem_addr_o;
    logic        mem_rd_o;
    logic [9:0]  mem_data_i = '0;
    logic [9:0]  sample_data_o;
    logic        sample_valid_o;
    logic        sample_ready_i = 1'b0;
    logic        period_done_o;
    logic        busy_o;

    always #5 clk = ~clk;

    wave_fetch_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (enable_i),
        .selector_i     (selector_i),
        .mem_addr_o     (mem_addr_o),
        .mem_rd_o       (mem_rd_o),
        .mem_data_i     (mem_data_i),
        .sample_data_o  (sample_data_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .period_done_o  (period_done_o),
        .busy_o         (busy_o)
    );

    // Registered sample memory: data = {addr[10:9], addr[7:0]}.
    always @(posedge clk) if (mem_rd_o) mem_data_i <= {mem_addr_o[10:9], mem_addr_o[7:0]};

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [10:0] exp_addr[$];
    logic [9:0]  exp_data[$];
    int          acc_cnt = 0, pd_cnt = 0, cyc = 0, last_acc = 0, gap_bad = 0;
    bit          tp_on = 0, tp_first = 0;
    logic [10:0] pd_addr_exp = '0;

    task automatic push(input logic [1:0] w, input logic [8:0] idx);
        exp_addr.push_back({w, idx});
        exp_data.push_back({w, idx[7:0]});
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (mem_rd_o) begin
                if (exp_addr.size() == 0) chk("expected_fetch_queue", 32'(exp_addr.size()), 1);
                else chk("mem_addr", mem_addr_o, exp_addr.pop_front());
            end
            if (sample_valid_o && sample_ready_i) begin
                if (exp_data.size() == 0) chk("expected_sample_queue", 32'(exp_data.size()), 1);
                else chk("sample_data", sample_data_o, exp_data.pop_front());
                if (tp_on && !tp_first && cyc - last_acc != 3) gap_bad++;
                tp_first = 0;
                last_acc = cyc;
                acc_cnt++;
            end
            if (period_done_o) begin
                pd_cnt++;
                chk("period_done_align", {mem_rd_o, mem_addr_o}, {1'b1, pd_addr_exp});
            end
        end
    end

    task automatic wait_acc(input int n);
        int base;
        int t;
        base = acc_cnt;
        t = 0;
        while (acc_cnt - base < n && t < n * 4 + 50) begin
            @(posedge clk);
            t++;
        end
        chk("accept_count", acc_cnt - base >= n, 1);
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b1;
        enable_i = 1'b0;
        sample_ready_i = 1'b0;
        tp_on = 0;
        @(posedge clk);
        #1;
        exp_addr.delete();
        exp_data.delete();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] sel;
        int         n;
        int         pd;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   pd0;
        int   step;
        int   t;
        vecs[0] = '{4'b0000, 6, 0};
        vecs[1] = '{4'b1011, 66, 1};
        vecs[2] = '{4'b0110, 130, 1};
        vecs[3] = '{4'b1101, 10, 0};
        vecs[4] = '{4'b0111, 66, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_mem_addr", mem_addr_o, 0);
        chk("reset_mem_rd", mem_rd_o, 0);
        chk("reset_sample_data", sample_data_o, 0);
        chk("reset_sample_valid", sample_valid_o, 0);
        chk("reset_period_done", period_done_o, 0);
        chk("reset_busy", busy_o, 0);
        rst = 1'b0;

        // Latency, then backpressure held for 10 cycles in PRESENT.
        push(0, 0); push(0, 1); push(0, 2);
        selector_i = 4'b0000;
        enable_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mem_rd_latency", mem_rd_o, 1);
        chk("valid_early", sample_valid_o, 0);
        @(negedge clk);
        chk("mem_rd_single", mem_rd_o, 0);
        chk("valid_capture", sample_valid_o, 0);
        @(negedge clk);
        chk("valid_latency", sample_valid_o, 1);
        chk("first_sample", sample_data_o, 10'h000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid_held", sample_valid_o, 1);
            chk("bp_data_stable", sample_data_o, 10'h000);
            chk("bp_no_mem_rd", mem_rd_o, 0);
        end
        @(posedge clk);
        #1 sample_ready_i = 1'b1;
        wait_acc(2);
        do_reset();

        // Table-driven free-running playback at full throughput.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            selector_i = vecs[i].sel;
            pd0 = pd_cnt;
            pd_addr_exp = {vecs[i].sel[3:2], 9'd0};
            step = 1 << vecs[i].sel[1:0];
            for (int k = 0; k < vecs[i].n + 4; k++) push(vecs[i].sel[3:2], 9'(k * step));
            tp_on = 1;
            tp_first = 1;
            sample_ready_i = 1'b1;
            enable_i = 1'b1;
            wait_acc(vecs[i].n);
            chk("period_done_count", pd_cnt - pd0, vecs[i].pd);
        end
        chk("throughput_gaps", gap_bad, 0);

        // Selector change mid-period only applies after the wrap.
        do_reset();
        selector_i = 4'b0000;
        for (int k = 0; k < 512; k++) push(0, 9'(k));
        for (int k = 0; k < 4; k++) push(1, 9'(k));
        pd_addr_exp = 11'h200;
        pd0 = pd_cnt;
        sample_ready_i = 1'b1;
        enable_i = 1'b1;
        wait_acc(100);
        @(posedge clk);
        #1 selector_i = 4'b0100;
        wait_acc(414);
        chk("switch_period_done", pd_cnt - pd0, 1);

        // Enable dropped during CAPTURE: finish the sample, go idle, restart at index 0.
        do_reset();
        selector_i = 4'b0000;
        push(0, 0);
        enable_i = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 enable_i = 1'b0;
        @(negedge clk);
        chk("busy_capture", busy_o, 1);
        @(negedge clk);
        chk("valid_after_drop", sample_valid_o, 1);
        @(posedge clk);
        #1 sample_ready_i = 1'b1;
        wait_acc(1);
        #1 sample_ready_i = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy_o, 0);
        chk("idle_valid", sample_valid_o, 0);
        repeat (3) @(negedge clk);
        chk("idle_stays", busy_o, 0);
        push(0, 0); push(0, 1);
        @(posedge clk);
        #1;
        enable_i = 1'b1;
        sample_ready_i = 1'b1;
        wait_acc(1);

        // Asynchronous reset while a sample is presented.
        do_reset();
        selector_i = 4'b1001;
        push(2, 0); push(2, 2); push(2, 4);
        enable_i = 1'b1;
        sample_ready_i = 1'b1;
        wait_acc(1);
        #1 sample_ready_i = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!sample_valid_o && t < 20);
        chk("pre_reset_valid", sample_valid_o, 1);
        chk("pre_reset_data", sample_data_o, 10'h202);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", sample_valid_o, 0);
        chk("async_busy", busy_o, 0);
        chk("async_mem_addr", mem_addr_o, 0);
        chk("async_sample_data", sample_data_o, 0);
        enable_i = 1'b0;
        selector_i = 4'b1100;
        @(posedge clk);
        #1;
        exp_addr.delete();
        exp_data.delete();
        rst = 1'b0;
        push(3, 0); push(3, 1); push(3, 2);
        enable_i = 1'b1;
        sample_ready_i = 1'b1;
        wait_acc(2);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
